quire_to_posit_4_0: RTL and testbench
=====================================

QUIRE_TO_POSIT_4_0 -- requirements
Module: quire_to_posit_4_0

Interface
REQ-001 SHALL have parameter EOW_ONLY, default 1: 1 = emit only end-of-window beats; 0 = convert every beat.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state on rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port rts_i, input, 1 bit: upstream beat valid.
REQ-005 SHALL have port rtr_o, output, 1 bit: ready to accept a beat.
REQ-006 SHALL have ports sow_i and eow_i, input, 1 bit each: start and end of the accumulation window.
REQ-007 SHALL have port data_i, input, 19 bits: signed two's-complement quire Q, value Q*2^-4.
REQ-008 SHALL have port NaR_i, input, 1 bit: the quire holds NaR.
REQ-009 SHALL have port rtr_i, input, 1 bit: downstream ready.
REQ-010 SHALL have ports rts_o, sow_o and eow_o, output, 1 bit each: output beat valid and window flags.
REQ-011 SHALL have port posit_o, output, 4 bits: posit<4,0> encoding.
REQ-012 SHALL have port sat_o, output, 1 bit: magnitude was clamped to maxpos.

Function
REQ-013 SHALL form process_en = rtr_i | ~rts_o and drive rtr_o = process_en combinationally; an input transfer is rts_i & rtr_o.
REQ-014 SHALL be a 2-stage pipeline with staged[0] and staged[1], both advancing only while process_en=1; a stage with no incoming beat is cleared when process_en=1.
REQ-015 Stage 1 SHALL register sign = data_i[18], M = |Q| as 19-bit unsigned (Q = -2^18 gives M = 2^18), NaR, sow and eow.
REQ-016 Stage 2 SHALL register the encoded posit, sat, sow and eow; rts_o = staged[1]; latency is 2 cycles from transfer to rts_o while rtr_i=1.
REQ-017 In EOW_ONLY=1, a transferred beat with eow_i=0 SHALL be consumed and dropped (staged[0] stays 0); an emitted beat has sow_o=1 and eow_o=1.
REQ-018 In EOW_ONLY=0, sow and eow SHALL pass through aligned with their data.
REQ-019 Positive rounding of M (units of 1/16) SHALL be: 0->0000; 1..5->0001; 6..10->0010; 11..13->0011; 14..20->0100; 21..27->0101; 28..48->0110; >=49->0111.
REQ-020 The thresholds SHALL implement nearest with ties-to-even on the encoding, never round a nonzero M to zero, and saturate at maxpos.
REQ-021 sign=1 SHALL produce the 4-bit two's complement of the positive encoding (e.g. -16 -> 1100).
REQ-022 NaR SHALL override and produce 1000 with sat_o=0.
REQ-023 sat_o SHALL be 1 only when M>64 and not NaR.
REQ-024 While rtr_i=0 and rts_o=1, all output registers SHALL hold; rtr_o=0 means no input is accepted.
REQ-025 Back-to-back beats with rtr_i=1 SHALL sustain 1 beat per cycle.

Reset
REQ-026 While rst_n=0, the block SHALL asynchronously clear staged[1:0], all sow/eow registers, posit_o, sat_o and the NaR registers to 0.
REQ-027 From reset, rts_o=0, posit_o=0000, sat_o=0 and rtr_o=1.
REQ-028 A reset asserted mid-stream SHALL discard in-flight beats with no output emitted; the first beat accepted after release appears 2 cycles later.

Structure
REQ-029 The shared package SHALL hold QUIRE_SIZE_4_0=19, QUIRE_FRAC_BITS_4_0=4, POSIT4_NAR=4'b1000, POSIT4_MAXPOS=4'b0111 and the seven rounding thresholds of REQ-019.
REQ-030 Magnitude-to-encoding mapping SHALL be one sub-module, posit_4_0_round, combinational, with input M and outputs {enc[2:0], sat}.
REQ-031 The top level SHALL hold the handshake, pipeline and filtering logic.

Verification
REQ-032 EOW_ONLY=0, Q = 16, 24, -24, 0, rtr_i=1 -> posit_o 0100, 0101, 1011, 0000 on consecutive cycles, first output 2 cycles after the first transfer.
REQ-033 Tie points Q = 6, 10, 14, 20, 28, 48, 49 -> 0010, 0010, 0100, 0100, 0110, 0110, 0111; Q=1 -> 0001; Q=-1 -> 1111.
REQ-034 Saturation: Q=65 -> 0111 with sat_o=1; Q=64 -> 0111 with sat_o=0; Q=-2^18 -> 1001 with sat_o=1.
REQ-035 EOW_ONLY=1, window of 5 beats ending at Q=32 with eow=1 -> exactly one output beat: 0110 with sow_o=1 and eow_o=1.
REQ-036 Backpressure: rtr_i=0 for 4 cycles with 3 beats offered -> rtr_o=0 once rts_o=1; no beat lost or duplicated; order preserved on release.
REQ-037 NaR_i=1 with Q=16 -> 1000; rst_n pulsed low with 2 beats in flight -> rts_o=0 immediately, no stale output afterwards.

Source files
------------

// File: rtl/quire_to_posit_4_0_pkg.sv
// Shared constants and types for converting a 19-bit quire into a posit<4,0>.
// The rounding thresholds are magnitudes in units of 1/16.
package quire_to_posit_4_0_pkg;

  localparam int QUIRE_SIZE_4_0      = 19;
  localparam int QUIRE_FRAC_BITS_4_0 = 4;

  localparam logic [3:0] POSIT4_NAR    = 4'b1000;
  localparam logic [3:0] POSIT4_MAXPOS = 4'b0111;

  typedef logic [QUIRE_SIZE_4_0-1:0] quire_mag_t;

  // Smallest magnitude that rounds to each encoding 001..111.
  localparam quire_mag_t RND_T1 = 19'd1;
  localparam quire_mag_t RND_T2 = 19'd6;
  localparam quire_mag_t RND_T3 = 19'd11;
  localparam quire_mag_t RND_T4 = 19'd14;
  localparam quire_mag_t RND_T5 = 19'd21;
  localparam quire_mag_t RND_T6 = 19'd28;
  localparam quire_mag_t RND_T7 = 19'd49;

  // maxpos is 4.0, which is 64 in quire units; anything above it is clamped.
  localparam quire_mag_t SAT_LIMIT = 19'd64;

  typedef struct packed {
    logic       sign;
    quire_mag_t mag;
    logic       nar;
    logic       sow;
    logic       eow;
  } stage1_t;

endpackage

// File: rtl/posit_4_0_round.sv
// Maps an unsigned quire magnitude onto the 3-bit positive posit<4,0> encoding.
// Nearest with ties-to-even, nonzero never rounds to zero, saturating at maxpos.
module posit_4_0_round
  import quire_to_posit_4_0_pkg::*;
(
  input  logic [QUIRE_SIZE_4_0-1:0] mag,
  output logic [2:0]                enc,
  output logic                      sat
);

  // NOTE: every output of a combinational block gets a default first, so no path
  // through the if-chain can leave it unassigned and infer a latch.
  always_comb begin
    enc = 3'd0;
    sat = (mag > SAT_LIMIT);
    if      (mag >= RND_T7) enc = 3'd7;
    else if (mag >= RND_T6) enc = 3'd6;
    else if (mag >= RND_T5) enc = 3'd5;
    else if (mag >= RND_T4) enc = 3'd4;
    else if (mag >= RND_T3) enc = 3'd3;
    else if (mag >= RND_T2) enc = 3'd2;
    else if (mag >= RND_T1) enc = 3'd1;
  end

endmodule

// File: rtl/quire_to_posit_4_0.sv
// Two-stage quire -> posit<4,0> converter with valid/ready handshake and an
// optional end-of-window filter that only forwards the final beat of a window.
module quire_to_posit_4_0
  import quire_to_posit_4_0_pkg::*;
#(
  parameter bit EOW_ONLY = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rts_i,
  output logic                      rtr_o,
  input  logic                      sow_i,
  input  logic                      eow_i,
  input  logic [QUIRE_SIZE_4_0-1:0] data_i,
  input  logic                      NaR_i,
  input  logic                      rtr_i,
  output logic                      rts_o,
  output logic                      sow_o,
  output logic                      eow_o,
  output logic [3:0]                posit_o,
  output logic                      sat_o
);

  logic                      process_en;
  logic                      xfer;
  logic                      keep;
  logic [1:0]                staged;
  logic [QUIRE_SIZE_4_0-1:0] mag_in;
  stage1_t                   s1;
  logic [2:0]                enc;
  logic                      rnd_sat;
  logic [3:0]                posit_next;
  logic                      sat_next;

  // The pipeline moves whenever the output slot is empty or being drained.
  assign process_en = rtr_i | ~rts_o;
  assign rtr_o      = process_en;
  assign xfer       = rts_i & process_en;
  assign keep       = xfer & (EOW_ONLY ? eow_i : 1'b1);
  assign rts_o      = staged[1];

  // Two's-complement negation of -2^18 wraps to 2^18, which is exactly |Q|.
  assign mag_in = data_i[QUIRE_SIZE_4_0-1] ? (~data_i + 19'd1) : data_i;

  // NOTE: the data registers are reset along with the valid bits; with only a
  // few dozen flops this keeps every output well defined right after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      staged[0] <= 1'b0;
      s1        <= '0;
    end else if (process_en) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      staged[0] <= keep;
      s1.sign   <= data_i[QUIRE_SIZE_4_0-1];
      s1.mag    <= mag_in;
      s1.nar    <= keep & NaR_i;
      s1.sow    <= keep & sow_i;
      s1.eow    <= keep & eow_i;
    end
  end

  posit_4_0_round u_round (
    .mag (s1.mag),
    .enc (enc),
    .sat (rnd_sat)
  );

  always_comb begin
    posit_next = {1'b0, enc};
    sat_next   = rnd_sat & ~s1.nar;
    if (s1.nar)       posit_next = POSIT4_NAR;
    else if (s1.sign) posit_next = 4'd0 - {1'b0, enc};
  end

  // Empty stage-2 slots are cleared so idle outputs read as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      staged[1] <= 1'b0;
      posit_o   <= 4'd0;
      sat_o     <= 1'b0;
      sow_o     <= 1'b0;
      eow_o     <= 1'b0;
    end else if (process_en) begin
      staged[1] <= staged[0];
      posit_o   <= staged[0] ? posit_next : 4'd0;
      sat_o     <= staged[0] & sat_next;
      sow_o     <= staged[0] & (EOW_ONLY ? 1'b1 : s1.sow);
      eow_o     <= staged[0] & (EOW_ONLY ? 1'b1 : s1.eow);
    end
  end

endmodule

// File: tb/tb_quire_to_posit_4_0.sv
// Directed bench for quire_to_posit_4_0: one instance converts every beat, a
// second (sharing the inputs) forwards only end-of-window beats.
module tb_quire_to_posit_4_0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rts_i, sow_i, eow_i, nar_i, rtr_i;
  logic [18:0] data_i;

  logic       rtr_o_a, rts_o_a, sow_o_a, eow_o_a, sat_o_a;
  logic [3:0] posit_o_a;
  logic       rtr_o_b, rts_o_b, sow_o_b, eow_o_b, sat_o_b;
  logic [3:0] posit_o_b;

  int checks = 0;
  int errors = 0;

  // Output beats observed at each handshake: {sow, eow, sat, posit}.
  logic [6:0] q_a[$];
  logic [6:0] q_b[$];

  always #5 clk = ~clk;

  quire_to_posit_4_0 #(.EOW_ONLY(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .rts_i(rts_i), .rtr_o(rtr_o_a),
    .sow_i(sow_i), .eow_i(eow_i), .data_i(data_i), .NaR_i(nar_i),
    .rtr_i(rtr_i), .rts_o(rts_o_a), .sow_o(sow_o_a), .eow_o(eow_o_a),
    .posit_o(posit_o_a), .sat_o(sat_o_a)
  );

  quire_to_posit_4_0 #(.EOW_ONLY(1'b1)) dut_eow (
    .clk(clk), .rst_n(rst_n), .rts_i(rts_i), .rtr_o(rtr_o_b),
    .sow_i(sow_i), .eow_i(eow_i), .data_i(data_i), .NaR_i(nar_i),
    .rtr_i(rtr_i), .rts_o(rts_o_b), .sow_o(sow_o_b), .eow_o(eow_o_b),
    .posit_o(posit_o_b), .sat_o(sat_o_b)
  );

  always @(posedge clk) begin
    if (rst_n && rtr_i && rts_o_a) q_a.push_back({sow_o_a, eow_o_a, sat_o_a, posit_o_a});
    if (rst_n && rtr_i && rts_o_b) q_b.push_back({sow_o_b, eow_o_b, sat_o_b, posit_o_b});
  end

  task automatic set_beat(input int q, input logic sow, input logic eow, input logic nar);
    rts_i  = 1'b1;
    data_i = 19'(q);
    sow_i  = sow;
    eow_i  = eow;
    nar_i  = nar;
  endtask

  task automatic go_idle();
    rts_i = 1'b0;
    sow_i = 1'b0;
    eow_i = 1'b0;
    nar_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rtr_i = 1'b1;
    data_i = '0;
    go_idle();
    repeat (2) @(negedge clk);
    checks++;
    if (rts_o_a !== 1'b0 || posit_o_a !== 4'b0000 || sat_o_a !== 1'b0 || rtr_o_a !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: rts=%b posit=%b sat=%b rtr=%b, want 0 0000 0 1",
               rts_o_a, posit_o_a, sat_o_a, rtr_o_a);
    end
    checks++;
    if (rts_o_b !== 1'b0 || rtr_o_b !== 1'b1 || sow_o_b !== 1'b0 || eow_o_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_state_eow: rts=%b rtr=%b sow=%b eow=%b, want 0 1 0 0",
               rts_o_b, rtr_o_b, sow_o_b, eow_o_b);
    end
    rst_n = 1'b1;
  endtask

  // Q = 16, 24, -24, 0 back-to-back; beat k presented at negedge k shows at negedge k+2.
  task automatic test_basic();
    int         vals[4] = '{16, 24, -24, 0};
    logic [3:0] exp[4]  = '{4'b0100, 4'b0101, 4'b1011, 4'b0000};
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      checks++;
      if (k < 2 || k > 5) begin
        if (rts_o_a !== 1'b0) begin
          errors++;
          $display("FAIL basic_idle[%0d]: rts=%b, want 0", k, rts_o_a);
        end
      end else if (rts_o_a !== 1'b1 || posit_o_a !== exp[k-2] || sat_o_a !== 1'b0) begin
        errors++;
        $display("FAIL basic_out[%0d]: rts=%b posit=%b sat=%b, want 1 %b 0",
                 k, rts_o_a, posit_o_a, sat_o_a, exp[k-2]);
      end
      if (k < 4) set_beat(vals[k], 1'b0, 1'b0, 1'b0);
      else       go_idle();
    end
    q_a.delete();
    q_b.delete();
  endtask

  // Ties, smallest nonzero, negatives, saturation and NaR, streamed with no gaps.
  task automatic test_rounding();
    localparam int N = 17;
    int         vals[N] = '{6, 10, 14, 20, 28, 48, 49, 1, -1, 65, 64, -262144,
                            16, 100, 11, -13, 5};
    logic       nars[N] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0};
    logic [4:0] exp[N]  = '{5'b0_0010, 5'b0_0010, 5'b0_0100, 5'b0_0100, 5'b0_0110,
                            5'b0_0110, 5'b0_0111, 5'b0_0001, 5'b0_1111, 5'b1_0111,
                            5'b0_0111, 5'b1_1001, 5'b0_1000, 5'b0_1000, 5'b0_0011,
                            5'b0_1101, 5'b0_0001};
    q_a.delete();
    q_b.delete();
    for (int k = 0; k < N + 2; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        checks++;
        if (rts_o_a !== 1'b1) begin
          errors++;
          $display("FAIL throughput[%0d]: rts=%b, want 1", k, rts_o_a);
        end
      end
      if (k < N) set_beat(vals[k], 1'b0, 1'b0, nars[k]);
      else       go_idle();
    end
    @(negedge clk);
    checks++;
    if (q_a.size() != N) begin
      errors++;
      $display("FAIL round_count: got %0d beats, want %0d", q_a.size(), N);
    end else begin
      for (int i = 0; i < N; i++) begin
        checks++;
        if (q_a[i][4:0] !== exp[i]) begin
          errors++;
          $display("FAIL round[Q=%0d nar=%0d]: sat,posit=%b, want %b",
                   vals[i], nars[i], q_a[i][4:0], exp[i]);
        end
      end
    end
    checks++;
    if (q_b.size() != 0) begin
      errors++;
      $display("FAIL eow_drop: eow-only instance emitted %0d beats, want 0", q_b.size());
    end
  endtask

  task automatic test_eow_window();
    int   vals[5] = '{3, 7, 9, 100, 32};
    logic sows[5] = '{1, 0, 0, 0, 0};
    logic eows[5] = '{0, 0, 0, 0, 1};
    q_a.delete();
    q_b.delete();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      set_beat(vals[k], sows[k], eows[k], 1'b0);
    end
    @(negedge clk);
    go_idle();
    repeat (3) @(negedge clk);
    checks++;
    if (q_b.size() != 1) begin
      errors++;
      $display("FAIL eow_count: got %0d beats, want 1", q_b.size());
    end else begin
      checks++;
      if (q_b[0] !== 7'b11_0_0110) begin
        errors++;
        $display("FAIL eow_beat: sow,eow,sat,posit=%b, want 1100110", q_b[0]);
      end
    end
    checks++;
    if (q_a.size() != 5) begin
      errors++;
      $display("FAIL window_count: got %0d beats, want 5", q_a.size());
    end else begin
      checks++;
      if (q_a[0][6:5] !== 2'b10 || q_a[4][6:5] !== 2'b01 || q_a[2][6:5] !== 2'b00) begin
        errors++;
        $display("FAIL window_flags: first=%b mid=%b last=%b, want 10 00 01",
                 q_a[0][6:5], q_a[2][6:5], q_a[4][6:5]);
      end
      checks++;
      if (q_a[3][4:0] !== 5'b1_0111 || q_a[4][4:0] !== 5'b0_0110) begin
        errors++;
        $display("FAIL window_data: beat3=%b beat4=%b, want 10111 00110",
                 q_a[3][4:0], q_a[4][4:0]);
      end
    end
  endtask

  task automatic test_backpressure();
    int         vals[3] = '{16, 24, 48};
    logic [3:0] exp[3]  = '{4'b0100, 4'b0101, 4'b0110};
    int         idx = 0;
    q_a.delete();
    @(negedge clk);
    rtr_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      if (c >= 2) begin
        checks++;
        if (rtr_o_a !== 1'b0 || rts_o_a !== 1'b1 || posit_o_a !== 4'b0100) begin
          errors++;
          $display("FAIL stall[%0d]: rtr=%b rts=%b posit=%b, want 0 1 0100",
                   c, rtr_o_a, rts_o_a, posit_o_a);
        end
      end
      if (idx < 3) begin
        set_beat(vals[idx], 1'b0, 1'b0, 1'b0);
        if (rtr_o_a) idx++;
      end
    end
    for (int c = 0; c < 10 && idx < 3; c++) begin
      @(negedge clk);
      rtr_i = 1'b1;
      #1;
      set_beat(vals[idx], 1'b0, 1'b0, 1'b0);
      if (rtr_o_a) idx++;
    end
    @(negedge clk);
    go_idle();
    rtr_i = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (idx != 3 || q_a.size() != 3) begin
      errors++;
      $display("FAIL bp_count: accepted %0d emitted %0d, want 3 3", idx, q_a.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (q_a[i][3:0] !== exp[i]) begin
          errors++;
          $display("FAIL bp_order[%0d]: posit=%b, want %b", i, q_a[i][3:0], exp[i]);
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    q_a.delete();
    @(negedge clk);
    set_beat(16, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    set_beat(24, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    go_idle();
    checks++;
    if (rts_o_a !== 1'b1) begin
      errors++;
      $display("FAIL midreset_inflight: rts=%b, want 1", rts_o_a);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (rts_o_a !== 1'b0 || posit_o_a !== 4'b0000) begin
      errors++;
      $display("FAIL midreset_async: rts=%b posit=%b, want 0 0000", rts_o_a, posit_o_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (q_a.size() != 0 || rts_o_a !== 1'b0) begin
      errors++;
      $display("FAIL midreset_stale: beats=%0d rts=%b, want 0 0", q_a.size(), rts_o_a);
    end
    set_beat(24, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    go_idle();
    checks++;
    if (rts_o_a !== 1'b0) begin
      errors++;
      $display("FAIL postreset_early: rts=%b, want 0", rts_o_a);
    end
    @(negedge clk);
    checks++;
    if (rts_o_a !== 1'b1 || posit_o_a !== 4'b0101) begin
      errors++;
      $display("FAIL postreset_beat: rts=%b posit=%b, want 1 0101", rts_o_a, posit_o_a);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_eow_window();
    test_backpressure();
    test_reset_midstream();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
